// File: rtl/addsub_pkg.sv
// Shared opcodes and flag bundle for the pipelined add/subtract unit.
package addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic cout;
        logic ovf;
        logic zero;
    } addsub_flags_t;

endpackage

// File: rtl/addsub_slice.sv
// Combinational ripple-carry chunk: one slice of the pipelined adder.
// Also exposes the carry into the chunk MSB so the top slice can derive overflow.
module addsub_slice #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [CHUNK:0] carry;

    // Ripple the carry bit by bit through the chunk.
    always_comb begin
        carry    = '0;
        s        = '0;
        carry[0] = ci;
        for (int i = 0; i < CHUNK; i++) begin
            s[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

    assign co    = carry[CHUNK];
    assign c_msb = carry[CHUNK-1];

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement add/subtract. The WIDTH-bit add is split into
// STAGES ripple chunks, one register stage per chunk. Operand chunks not yet
// consumed ride along in skew registers; finished low sum chunks travel with
// the operation. The whole pipeline advances together when the output slot
// is free or being drained.
module pipelined_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    import addsub_pkg::*;

    localparam int CHUNK = WIDTH / STAGES;

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
        $error("pipelined_addsub: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
    end

    logic adv;
    logic accept;

    // What each stage sees at its input (stage 0: the port, stage k: register k-1).
    logic             stg_v    [STAGES];
    logic [WIDTH-1:0] stg_a    [STAGES];
    logic [WIDTH-1:0] stg_b    [STAGES];
    logic [WIDTH-1:0] stg_s    [STAGES];
    logic             stg_c    [STAGES];

    logic [CHUNK-1:0] slice_s  [STAGES];
    logic             slice_co [STAGES];
    logic             slice_cm [STAGES];
    logic [WIDTH-1:0] s_next   [STAGES];

    // Stage registers; the last stage doubles as the output register.
    logic             v_reg    [STAGES];
    logic [WIDTH-1:0] a_reg    [STAGES];
    logic [WIDTH-1:0] b_reg    [STAGES];
    logic [WIDTH-1:0] s_reg    [STAGES];
    logic             c_reg    [STAGES];

    addsub_flags_t    flags_reg;
    addsub_flags_t    flags_next;

    assign adv      = !v_reg[STAGES-1] || out_ready;
    assign in_ready = adv && !flush && rst_n;
    assign accept   = in_valid && in_ready;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            localparam int LO = gi * CHUNK;
            localparam logic [WIDTH-1:0] MASK = ((WIDTH'(1) << CHUNK) - WIDTH'(1)) << LO;

            if (gi == 0) begin : g_first
                // Subtraction is A + ~B + ~borrow.
                assign stg_v[gi] = accept;
                assign stg_a[gi] = a;
                assign stg_b[gi] = (sub == OP_SUB) ? ~b : b;
                assign stg_c[gi] = (sub == OP_SUB) ? ~cin : cin;
                assign stg_s[gi] = '0;
            end else begin : g_rest
                assign stg_v[gi] = v_reg[gi-1];
                assign stg_a[gi] = a_reg[gi-1];
                assign stg_b[gi] = b_reg[gi-1];
                assign stg_c[gi] = c_reg[gi-1];
                assign stg_s[gi] = s_reg[gi-1];
            end

            addsub_slice #(.CHUNK(CHUNK)) u_slice (
                .a     (stg_a[gi][LO +: CHUNK]),
                .b     (stg_b[gi][LO +: CHUNK]),
                .ci    (stg_c[gi]),
                .s     (slice_s[gi]),
                .co    (slice_co[gi]),
                .c_msb (slice_cm[gi])
            );

            // Drop this stage's sum chunk into its place in the running result.
            assign s_next[gi] = (stg_s[gi] & ~MASK) | (WIDTH'(slice_s[gi]) << LO);
        end
    endgenerate

    // Flags are formed from the completed sum leaving the top slice.
    always_comb begin
        flags_next      = '0;
        flags_next.cout = slice_co[STAGES-1];
        flags_next.ovf  = slice_co[STAGES-1] ^ slice_cm[STAGES-1];
        flags_next.zero = (s_next[STAGES-1] == '0);
    end

    // Pipeline registers: valid bits obey flush, everything moves only on adv.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                v_reg[k] <= 1'b0;
                a_reg[k] <= '0;
                b_reg[k] <= '0;
                s_reg[k] <= '0;
                c_reg[k] <= 1'b0;
            end
            flags_reg <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (flush) begin
                    v_reg[k] <= 1'b0;
                end else if (adv) begin
                    v_reg[k] <= stg_v[k];
                end
                if (adv) begin
                    a_reg[k] <= stg_a[k];
                    b_reg[k] <= stg_b[k];
                    s_reg[k] <= s_next[k];
                    c_reg[k] <= slice_co[k];
                end
            end
            if (adv) begin
                flags_reg <= flags_next;
            end
        end
    end

    assign out_valid = v_reg[STAGES-1];
    assign sum       = s_reg[STAGES-1];
    assign cout      = flags_reg.cout;
    assign ovf       = flags_reg.ovf;
    assign zero      = flags_reg.zero;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub: an 8-bit/4-stage unit with directed
// and random traffic, plus 32-bit/1-stage and 32-bit/8-stage units with random
// traffic and a mid-stream asynchronous reset.
module tb_pipelined_addsub;

    localparam int W = 8;
    localparam int S = 4;

    typedef struct {
        longint unsigned sum;
        bit              cout;
        bit              ovf;
        bit              zero;
    } exp_t;

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the operands' unsigned and signed values.
    function automatic exp_t model(input int w, input longint unsigned av, input longint unsigned bv,
                                   input bit s, input bit c);
        exp_t   e;
        longint modv = longint'(64'd1 << w);
        longint half = modv / 2;
        longint ua   = longint'(av);
        longint ub   = longint'(bv);
        longint ci   = c ? 1 : 0;
        longint sa   = (ua >= half) ? ua - modv : ua;
        longint sb   = (ub >= half) ? ub - modv : ub;
        longint u;
        longint r;
        if (s) begin
            u = ua - ub - ci + modv;
            r = sa - sb - ci;
        end else begin
            u = ua + ub + ci;
            r = sa + sb + ci;
        end
        e.cout = (u >= modv);
        e.sum  = longint'(u % modv);
        e.ovf  = (r < -half) || (r > half - 1);
        e.zero = (e.sum == 0);
        return e;
    endfunction

    // Operand generator biased toward the interesting corners.
    function automatic longint unsigned pick(input int w);
        longint unsigned m = (64'd1 << w) - 1;
        case ($urandom_range(0, 7))
            0:       return 0;
            1:       return m;
            2:       return m >> 1;
            3:       return 64'd1 << (w - 1);
            default: return longint'($urandom) & m;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------------------------------------------------------- main DUT
    logic         rst_n, flush, in_valid, in_ready, sub, cin;
    logic         out_valid, out_ready, cout, ovf, zero;
    logic [W-1:0] a, b, sum;

    pipelined_addsub #(.WIDTH(W), .STAGES(S)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    exp_t q0[$];
    int   pops0 = 0;

    // Monitor: push expectation on accept, pop and compare on every output transfer.
    always @(negedge clk) begin : mon0
        exp_t e;
        if (!rst_n || flush) begin
            q0.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (q0.size() == 0) begin
                    check("spurious_out_valid", out_valid, 0);
                end else begin
                    e = q0.pop_front();
                    check("sum", sum, e.sum);
                    check("cout", cout, e.cout);
                    check("ovf", ovf, e.ovf);
                    check("zero", zero, e.zero);
                    $display("out: sum=%02h cout=%0b ovf=%0b zero=%0b", sum, cout, ovf, zero);
                    pops0++;
                end
            end
            if (in_valid && in_ready) begin
                q0.push_back(model(W, a, b, sub, cin));
                $display("in : a=%02h b=%02h sub=%0b cin=%0b", a, b, sub, cin);
            end
        end
    end

    // Present one operation and hold it until accepted; returns just after the accepting edge.
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts, input logic tc);
        int n = 0;
        a = ta; b = tb; sub = ts; cin = tc; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_timeout", in_ready, 1);
        @(posedge clk); #1;
    endtask

    // Single operation into an idle pipeline: exact latency plus known answer.
    task automatic op_latency(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts,
                              input logic tc, input logic [W-1:0] es, input logic ec,
                              input logic eo, input logic ez);
        int n = 0;
        send(ta, tb, ts, tc);
        in_valid = 1'b0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        check("latency", n, S);
        check("kat_sum", sum, es);
        check("kat_cout", cout, ec);
        check("kat_ovf", ovf, eo);
        check("kat_zero", zero, ez);
        @(posedge clk); #1;
    endtask

    // Hold off the consumer for three cycles once the first result shows up.
    task automatic stall_watch();
        int           n = 0;
        logic [W-1:0] hs;
        logic         hc, ho, hz;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 30);
        check("stall_first_result", out_valid, 1);
        check("stall_in_ready", in_ready, 0);
        hs = sum; hc = cout; ho = ovf; hz = zero;
        repeat (2) begin
            @(negedge clk);
            check("stall_out_valid", out_valid, 1);
            check("stall_in_ready", in_ready, 0);
            check("stall_sum_hold", sum, hs);
            check("stall_flags_hold", {cout, ovf, zero}, {hc, ho, hz});
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
    endtask

    typedef struct {
        logic [W-1:0] a, b;
        logic         s, c;
        logic [W-1:0] es;
        logic         ec, eo, ez;
    } kat_t;

    kat_t kats[7] = '{
        '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1},
        '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0},
        '{8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0},
        '{8'h05, 8'h07, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0},
        '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFD, 1'b0, 1'b0, 1'b0},
        '{8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1},
        '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1}
    };

    // ------------------------------------------------ wide configurations
    localparam int NCFG = 2;
    localparam int CFG_S [NCFG] = '{1, 8};
    bit cfg_done [NCFG];

    genvar gi;
    generate
        for (gi = 0; gi < NCFG; gi++) begin : g_cfg
            localparam int SW = 32;
            localparam int SS = CFG_S[gi];

            logic          r_rst_n, r_flush, r_in_valid, r_in_ready, r_sub, r_cin;
            logic          r_out_valid, r_out_ready, r_cout, r_ovf, r_zero;
            logic [SW-1:0] r_a, r_b, r_sum;
            exp_t          q[$];

            pipelined_addsub #(.WIDTH(SW), .STAGES(SS)) u_dut (
                .clk       (clk),
                .rst_n     (r_rst_n),
                .flush     (r_flush),
                .in_valid  (r_in_valid),
                .in_ready  (r_in_ready),
                .a         (r_a),
                .b         (r_b),
                .sub       (r_sub),
                .cin       (r_cin),
                .out_valid (r_out_valid),
                .out_ready (r_out_ready),
                .sum       (r_sum),
                .cout      (r_cout),
                .ovf       (r_ovf),
                .zero      (r_zero)
            );

            always @(negedge clk) begin : mon
                exp_t e;
                if (!r_rst_n || r_flush) begin
                    q.delete();
                end else begin
                    if (r_out_valid && r_out_ready) begin
                        if (q.size() == 0) begin
                            check($sformatf("cfg%0d_spurious_out_valid", gi), r_out_valid, 0);
                        end else begin
                            e = q.pop_front();
                            check($sformatf("cfg%0d_sum", gi), r_sum, e.sum);
                            check($sformatf("cfg%0d_flags", gi), {r_cout, r_ovf, r_zero},
                                  {e.cout, e.ovf, e.zero});
                            $display("cfg%0d out: sum=%08h cout=%0b ovf=%0b zero=%0b",
                                     gi, r_sum, r_cout, r_ovf, r_zero);
                        end
                    end
                    if (r_in_valid && r_in_ready) begin
                        q.push_back(model(SW, r_a, r_b, r_sub, r_cin));
                    end
                end
            end

            initial begin
                r_rst_n = 1'b1; r_flush = 1'b0; r_in_valid = 1'b0; r_out_ready = 1'b1;
                r_a = '0; r_b = '0; r_sub = 1'b0; r_cin = 1'b0;
                #1 r_rst_n = 1'b0;
                repeat (2) @(posedge clk);
                #1 r_rst_n = 1'b1;
                for (int i = 0; i < 300; i++) begin
                    if (i == 150) begin
                        r_rst_n = 1'b0;
                        @(negedge clk);
                        check($sformatf("cfg%0d_rst_out_valid", gi), r_out_valid, 0);
                        check($sformatf("cfg%0d_rst_in_ready", gi), r_in_ready, 0);
                        check($sformatf("cfg%0d_rst_sum", gi), r_sum, 0);
                        @(posedge clk); #1;
                        r_rst_n = 1'b1;
                    end
                    r_in_valid  = ($urandom_range(0, 3) != 0);
                    r_out_ready = ($urandom_range(0, 3) != 0);
                    r_a   = SW'(pick(SW));
                    r_b   = SW'(pick(SW));
                    r_sub = 1'($urandom_range(0, 1));
                    r_cin = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
                r_in_valid  = 1'b0;
                r_out_ready = 1'b1;
                repeat (SS + 4) @(negedge clk);
                #1;
                check($sformatf("cfg%0d_drained", gi), q.size(), 0);
                cfg_done[gi] = 1'b1;
            end
        end
    endgenerate

    // ------------------------------------------------------- main sequence
    initial begin
        int start;
        int seen;
        int n;
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; sub = 1'b0; cin = 1'b0;

        // Reset state, with an operation offered during reset.
        #1 rst_n = 1'b0;
        in_valid = 1'b1; a = 8'h12; b = 8'h34;
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_flags", {cout, ovf, zero}, 3'b000);
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Known-answer vectors into an idle pipeline.
        foreach (kats[i])
            op_latency(kats[i].a, kats[i].b, kats[i].s, kats[i].c,
                       kats[i].es, kats[i].ec, kats[i].eo, kats[i].ez);

        // Six back-to-back operations with a three-cycle consumer stall.
        out_ready = 1'b0;
        start = pops0;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(W'(pick(W)), W'(pick(W)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                in_valid = 1'b0;
            end
            stall_watch();
        join
        repeat (12) @(negedge clk);
        #1;
        check("stream_count", pops0 - start, 6);
        @(posedge clk); #1;

        // Flush one cycle before the first result; the offer during flush is refused.
        for (int i = 0; i < 3; i++)
            send(W'(pick(W)), W'(pick(W)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        a = 8'h11; b = 8'h22; sub = 1'b0; cin = 1'b0; in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        check("flush_in_ready", in_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("flush_no_out_valid", seen, 0);
        @(posedge clk); #1;
        op_latency(8'h11, 8'h22, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0);

        // Random traffic with random back-pressure and an async reset mid-stream.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                rst_n = 1'b0;
                @(negedge clk);
                check("midrst_out_valid", out_valid, 0);
                check("midrst_in_ready", in_ready, 0);
                check("midrst_sum", sum, 0);
                @(posedge clk); #1;
                rst_n = 1'b1;
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            a   = W'(pick(W));
            b   = W'(pick(W));
            sub = 1'($urandom_range(0, 1));
            cin = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (S + 4) @(negedge clk);
        #1;
        check("main_drained", q0.size(), 0);

        n = 0;
        while (!(cfg_done[0] && cfg_done[1]) && n < 5000) begin
            @(posedge clk);
            n++;
        end
        check("cfg_done", cfg_done[0] && cfg_done[1], 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Last-resort bound on total run time.
    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
